h3_multi_hash_unit: RTL and testbench

Pipelined, multi-way H3 hash engine for the cuckoo/multi-choice hashtable datapath. It stores its own H3 matrices for NUM_HASHES independent hash functions, computes all of them for one key per cycle behind a valid/ready handshake, and returns the key with the packed addresses two cycles later. Matrices are written row-by-row over a config port, or regenerated internally from a seed by a reseed state machine, which quiesces the pipeline first.

---
 rtl/h3_multi_hash_unit.sv | 161 ++++++++++++++++
 tb/tb_h3_multi_hash_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/h3_multi_hash_unit.sv
// Pipelined multi-way H3 hash engine: NUM_HASHES hash functions over one key per cycle,
// with a row-writable matrix and an internal xorshift32 reseed sequencer.
`timescale 1ns/1ps
module h3_multi_hash_unit #(
    parameter int unsigned KEY_WIDTH      = 32,
    parameter int unsigned HASH_ADR_WIDTH = 5,
    parameter int unsigned NUM_HASHES     = 2,
    parameter logic [31:0] SEED           = 32'hACE1_2468,
    localparam int unsigned ROWS          = NUM_HASHES * HASH_ADR_WIDTH,
    localparam int unsigned ROW_W         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [KEY_WIDTH-1:0] key_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic [ROWS-1:0]      hash_adr_out,
    input  logic                 cfg_we,
    input  logic [ROW_W-1:0]     cfg_row,
    input  logic [KEY_WIDTH-1:0] cfg_data,
    input  logic                 reseed_start,
    input  logic [31:0]          cfg_seed,
    output logic                 cfg_busy,
    output logic                 reseed_done
);

    typedef enum logic [1:0] {StIdle, StDrain, StReseed} state_e;

    state_e               state_q, state_d;
    logic [31:0]          seed_q, seed_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 done_q, done_d;

    logic [KEY_WIDTH-1:0] matrix_q [ROWS];

    logic                 s1_valid_q, s2_valid_q;
    logic [KEY_WIDTH-1:0] s1_key_q, s2_key_q;
    logic [ROWS-1:0]      s2_hash_q, hash_d;

    logic                 s1_free, s2_free, in_accept, cfg_in_range, row_last;
    logic [31:0]          xs_next;
    logic [KEY_WIDTH-1:0] row_val;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    assign s2_free      = !s2_valid_q || out_ready;
    assign s1_free      = !s1_valid_q || s2_free;
    assign in_ready     = (state_q == StIdle) && s1_free;
    assign in_accept    = in_valid && in_ready;
    assign cfg_in_range = (32'(cfg_row) < ROWS);
    assign row_last     = (row_q == ROW_W'(ROWS - 1));

    assign out_valid    = s2_valid_q;
    assign key_out      = s2_key_q;
    assign hash_adr_out = s2_hash_q;
    assign cfg_busy     = (state_q != StIdle);
    assign reseed_done  = done_q;

    // Row r of the matrix produces bit r of the packed hash vector.
    always_comb begin
        hash_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            hash_d[r] = ^(s1_key_q & matrix_q[r]);
        end
    end

    // The 32-bit generator state is tiled across the key width.
    always_comb begin
        xs_next = xorshift32(seed_q);
        row_val = '0;
        for (int i = 0; i < KEY_WIDTH; i++) begin
            row_val[i] = xs_next[i[4:0]];
        end
    end

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        row_d   = row_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (reseed_start) begin
                    seed_d  = (cfg_seed == '0) ? SEED : cfg_seed;
                    row_d   = '0;
                    // Skip DRAIN when nothing is in flight and nothing enters this cycle.
                    state_d = (!s1_valid_q && !s2_valid_q && !in_accept) ? StReseed : StDrain;
                end
            end
            StDrain: begin
                if (!s1_valid_q && !s2_valid_q) state_d = StReseed;
            end
            StReseed: begin
                seed_d = xs_next;
                row_d  = row_q + 1'b1;
                if (row_last) begin
                    row_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            seed_q  <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) matrix_q[r] <= '0;
        end else if (state_q == StReseed) begin
            matrix_q[row_q] <= row_val;
        end else if ((state_q == StIdle) && cfg_we && cfg_in_range) begin
            matrix_q[cfg_row] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_key_q   <= '0;
            s2_key_q   <= '0;
            s2_hash_q  <= '0;
        end else begin
            if (s1_free) begin
                s1_valid_q <= in_accept;
                if (in_accept) s1_key_q <= key_in;
            end
            if (s2_free) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_key_q  <= s1_key_q;
                    s2_hash_q <= hash_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_h3_multi_hash_unit.sv
// Directed, table-driven bench for h3_multi_hash_unit with default parameters.
`timescale 1ns/1ps
module tb_h3_multi_hash_unit;

    localparam int KW   = 32;
    localparam int HW   = 5;
    localparam int ROWS = 10;
    localparam int RW   = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [KW-1:0] key_in, key_out, cfg_data;
    logic [ROWS-1:0] hash_adr_out;
    logic          cfg_we, reseed_start, cfg_busy, reseed_done;
    logic [RW-1:0] cfg_row;
    logic [31:0]   cfg_seed;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [KW-1:0] mdl [ROWS];

    typedef struct {
        logic [31:0] key;
        logic [4:0]  h0;
        logic [4:0]  h1;
    } vec_t;
    vec_t tbl [6];

    h3_multi_hash_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .key_in       (key_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .key_out      (key_out),
        .hash_adr_out (hash_adr_out),
        .cfg_we       (cfg_we),
        .cfg_row      (cfg_row),
        .cfg_data     (cfg_data),
        .reseed_start (reseed_start),
        .cfg_seed     (cfg_seed),
        .cfg_busy     (cfg_busy),
        .reseed_done  (reseed_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [ROWS-1:0] model_hash(input logic [KW-1:0] k);
        logic [ROWS-1:0] h;
        for (int r = 0; r < ROWS; r++) h[r] = ^(k & mdl[r]);
        return h;
    endfunction

    task automatic model_reseed(input logic [31:0] seed);
        logic [31:0] x;
        x = seed;
        for (int r = 0; r < ROWS; r++) begin
            x = xs32(x);
            mdl[r] = x;
        end
    endtask

    task automatic write_row(input int r, input logic [KW-1:0] d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_row  = RW'(r);
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (r < ROWS) mdl[r] = d;
    endtask

    // One key through an idle pipeline; checks exact two-edge latency.
    task automatic send_key(input logic [KW-1:0] k, input logic [ROWS-1:0] exp, input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        key_in   = k;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".early"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        check({tag, ".valid"}, 64'(out_valid), 64'(1));
        check({tag, ".key"}, 64'(key_out), 64'(k));
        check({tag, ".hash"}, 64'(hash_adr_out), 64'(exp));
    endtask

    // Probes every matrix bit through one-hot keys.
    task automatic verify_matrix(input string tag);
        for (int b = 0; b < KW; b++) begin
            logic [KW-1:0] k;
            k = KW'(1) << b;
            send_key(k, model_hash(k), $sformatf("%s.bit%0d", tag, b));
        end
    endtask

    initial begin
        logic [KW-1:0] keys [16];
        logic [3:0]    rdy_pat;
        logic [KW-1:0] k_a, k_b;
        logic [ROWS-1:0] h_a, h_b;
        int sent, rcv, cyc, first_out, busy, n, pulses;

        tbl[0] = '{32'h0000_003F, 5'h1F, 5'h1F};
        tbl[1] = '{32'h0000_0020, 5'h00, 5'h10};
        tbl[2] = '{32'h0000_0001, 5'h01, 5'h00};
        tbl[3] = '{32'h0000_002A, 5'h0A, 5'h15};
        tbl[4] = '{32'hFFFF_FFC0, 5'h00, 5'h00};
        tbl[5] = '{32'h0000_0015, 5'h15, 5'h0A};

        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; key_in = '0;
        cfg_we = 1'b0; cfg_row = '0; cfg_data = '0;
        reseed_start = 1'b0; cfg_seed = '0;
        for (int r = 0; r < ROWS; r++) mdl[r] = '0;

        // Reset
        repeat (2) @(negedge clk);
        check("rst.out_valid_in_reset", 64'(out_valid), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'(1));
        check("rst.out_valid", 64'(out_valid), 64'(0));
        check("rst.key_out", 64'(key_out), 64'(0));
        check("rst.hash", 64'(hash_adr_out), 64'(0));
        check("rst.cfg_busy", 64'(cfg_busy), 64'(0));
        check("rst.reseed_done", 64'(reseed_done), 64'(0));
        send_key(32'hFFFF_FFFF, '0, "zero_matrix");

        // Identity load plus out-of-range writes that must be dropped
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < HW; j++)
                write_row(k * HW + j, KW'(1) << (j + k));
        write_row(10, 32'hFFFF_FFFF);
        write_row(15, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++)
            send_key(tbl[i].key, {tbl[i].h1, tbl[i].h0}, $sformatf("ident%0d", i));

        // Streaming with out_ready pattern 1,0,0,1
        for (int r = 0; r < ROWS; r++) write_row(r, 32'h1357_9BDF * (r + 3));
        for (int i = 0; i < 16; i++) keys[i] = 32'h9E37_79B9 * (i + 1);
        rdy_pat = 4'b1001;
        sent = 0; rcv = 0; cyc = 0; first_out = -1;
        while (rcv < 16 && cyc < 200) begin
            @(negedge clk);
            out_ready = rdy_pat[cyc % 4];
            in_valid  = (sent < 16);
            key_in    = (sent < 16) ? keys[sent] : '0;
            #1;
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d.key", rcv), 64'(key_out), 64'(keys[rcv]));
                check($sformatf("stream%0d.hash", rcv), 64'(hash_adr_out),
                      64'(model_hash(keys[rcv])));
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream.count", 64'(rcv), 64'(16));
        check("stream.first_latency", 64'(first_out), 64'(2));
        repeat (3) @(negedge clk);
        check("stream.no_extra", 64'(out_valid), 64'(0));

        // Reseed on an empty pipeline; concurrent cfg_we is overwritten, busy-time write ignored
        @(negedge clk);
        reseed_start = 1'b1; cfg_seed = '0;
        cfg_we = 1'b1; cfg_row = '0; cfg_data = 32'hFFFF_FFFF;
        @(negedge clk);
        reseed_start = 1'b0; cfg_we = 1'b0;
        busy = 0; n = 0;
        while (cfg_busy && n < 50) begin
            cfg_we   = (busy == 5);
            cfg_row  = '0;
            cfg_data = '0;
            busy++;
            @(negedge clk);
            n++;
        end
        cfg_we = 1'b0;
        check("reseed.busy_cycles", 64'(busy), 64'(10));
        check("reseed.done_pulse", 64'(reseed_done), 64'(1));
        @(negedge clk);
        check("reseed.done_clear", 64'(reseed_done), 64'(0));
        model_reseed(32'hACE1_2468);
        verify_matrix("seed_default");

        // Reseed while the pipeline is full and stalled
        k_a = 32'hCAFE_F00D; k_b = 32'h0BAD_BEEF;
        h_a = model_hash(k_a); h_b = model_hash(k_b);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; key_in = k_a;
        @(negedge clk);
        key_in = k_b;
        @(negedge clk);
        in_valid = 1'b0; reseed_start = 1'b1; cfg_seed = 32'h1234_5678;
        @(negedge clk);
        reseed_start = 1'b0;
        busy = 0; rcv = 0; n = 0;
        while (cfg_busy && n < 60) begin
            out_ready = (n >= 5);
            if (n < 5) begin
                check($sformatf("drain.in_ready%0d", n), 64'(in_ready), 64'(0));
                check($sformatf("drain.hold%0d", n), 64'(key_out), 64'(k_a));
            end
            if (out_valid && out_ready) begin
                check($sformatf("drain.key%0d", rcv), 64'(key_out),
                      64'((rcv == 0) ? k_a : k_b));
                check($sformatf("drain.hash%0d", rcv), 64'(hash_adr_out),
                      64'((rcv == 0) ? h_a : h_b));
                rcv++;
            end
            busy++;
            @(negedge clk);
            n++;
        end
        out_ready = 1'b1;
        check("drain.results", 64'(rcv), 64'(2));
        check("drain.busy_cycles", 64'(busy), 64'(18));
        check("drain.done_pulse", 64'(reseed_done), 64'(1));
        model_reseed(32'h1234_5678);
        verify_matrix("seed_user");

        // Reset in the middle of a reseed
        @(negedge clk);
        reseed_start = 1'b1; cfg_seed = 32'hDEAD_BEEF;
        @(negedge clk);
        reseed_start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst.cfg_busy", 64'(cfg_busy), 64'(0));
        check("midrst.out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (reseed_done) pulses++;
        end
        check("midrst.no_done", 64'(pulses), 64'(0));
        check("midrst.busy_after", 64'(cfg_busy), 64'(0));
        for (int r = 0; r < ROWS; r++) mdl[r] = '0;
        verify_matrix("midrst_zero");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
